// File: rtl/carry_select_lookahead_adder.sv
// carry_select_lookahead_adder
// Registered DATA_WIDTH-bit adder: {carry_o,result_o} = operand_A_i + operand_B_i + carry_i.
// Carry-select chain over BLOCK_WIDTH-bit carry-lookahead sub-blocks, one output register stage.
// Optional macro CSEL_ADDER_OVERFLOW_EN adds a registered signed-overflow flag (overflow_o).

module carry_select_lookahead_adder #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    input  logic                  carry_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o,
`ifdef CSEL_ADDER_OVERFLOW_EN
    output logic                  overflow_o,
`endif
    output logic                  valid_o
);

    localparam int unsigned BW         = BLOCK_WIDTH;
    localparam int unsigned NUM_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;

    if ((DATA_WIDTH % BLOCK_WIDTH) != 0) begin : g_width_check
        $error("DATA_WIDTH (%0d) must be a multiple of BLOCK_WIDTH (%0d)", DATA_WIDTH, BLOCK_WIDTH);
    end

    // Lookahead block: returns {cout, sum}. Each carry is built as a flat
    // sum-of-products of generate/propagate terms rather than a ripple.
    function automatic logic [BLOCK_WIDTH:0] cla(
        input logic [BLOCK_WIDTH-1:0] a,
        input logic [BLOCK_WIDTH-1:0] b,
        input logic                   cin
    );
        logic [BLOCK_WIDTH-1:0] g;
        logic [BLOCK_WIDTH-1:0] p;
        logic [BLOCK_WIDTH:0]   c;
        logic [BLOCK_WIDTH-1:0] s;
        logic                   term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < BW; i++) begin
            // cin term: all propagates p[i:0] set
            term = cin;
            for (int unsigned k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c[i+1] = term;
            // generate at j, propagated through p[i:j+1]
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        s = p ^ c[BLOCK_WIDTH-1:0];
        return {c[BLOCK_WIDTH], s};
    endfunction

    logic [NUM_BLOCKS:0]   blk_c;
    logic [DATA_WIDTH-1:0] sum_c;

    assign blk_c[0] = carry_i;

    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_blk
        logic [BLOCK_WIDTH-1:0] a_blk;
        logic [BLOCK_WIDTH-1:0] b_blk;
        assign a_blk = operand_A_i[k*BLOCK_WIDTH +: BLOCK_WIDTH];
        assign b_blk = operand_B_i[k*BLOCK_WIDTH +: BLOCK_WIDTH];
        if (k == 0) begin : g_first
            logic [BLOCK_WIDTH:0] r;
            assign r                               = cla(a_blk, b_blk, carry_i);
            assign sum_c[BLOCK_WIDTH-1:0]          = r[BLOCK_WIDTH-1:0];
            assign blk_c[1]                        = r[BLOCK_WIDTH];
        end else begin : g_sel
            logic [BLOCK_WIDTH:0] r0;
            logic [BLOCK_WIDTH:0] r1;
            logic [BLOCK_WIDTH:0] rs;
            assign r0 = cla(a_blk, b_blk, 1'b0);
            assign r1 = cla(a_blk, b_blk, 1'b1);
            // previous block carry-out picks the precomputed result
            assign rs = blk_c[k] ? r1 : r0;
            assign sum_c[k*BLOCK_WIDTH +: BLOCK_WIDTH] = rs[BLOCK_WIDTH-1:0];
            assign blk_c[k+1]                          = rs[BLOCK_WIDTH];
        end
    end

    logic [DATA_WIDTH-1:0] result_d, result_q;
    logic                  carry_d, carry_q;
    logic                  valid_q;

    assign result_d = sum_c;
    assign carry_d  = blk_c[NUM_BLOCKS];

`ifdef CSEL_ADDER_OVERFLOW_EN
    logic overflow_d, overflow_q;
    assign overflow_d = (operand_A_i[DATA_WIDTH-1] == operand_B_i[DATA_WIDTH-1]) &&
                        (sum_c[DATA_WIDTH-1] != operand_A_i[DATA_WIDTH-1]);

    // overflow flag registered with the sum, held while idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q <= 1'b0;
        end else if (valid_i) begin
            overflow_q <= overflow_d;
        end
    end
    assign overflow_o = overflow_q;
`endif

    // output stage: capture sum on valid_i, hold otherwise; reset overrides
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                result_q <= result_d;
                carry_q  <= carry_d;
            end
        end
    end

    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign valid_o  = valid_q;

endmodule

// File: tb/tb_carry_select_lookahead_adder.sv
// Directed and random checks for carry_select_lookahead_adder (32-bit, 4-bit blocks).

module tb_carry_select_lookahead_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] result;
    logic        cout;
    logic        valid_out;
`ifdef CSEL_ADDER_OVERFLOW_EN
    logic        ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    carry_select_lookahead_adder #(
        .DATA_WIDTH (32),
        .BLOCK_WIDTH(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid_in),
        .operand_A_i(a),
        .operand_B_i(b),
        .carry_i    (cin),
        .result_o   (result),
        .carry_o    (cout),
`ifdef CSEL_ADDER_OVERFLOW_EN
        .overflow_o (ovf),
`endif
        .valid_o    (valid_out)
    );

    // drive inputs away from the edge, then sample 1ns after the edge
    task automatic step(input logic r, input logic v, input logic [31:0] ta,
                        input logic [31:0] tb, input logic tc);
        @(negedge clk);
        rst      = r;
        valid_in = v;
        a        = ta;
        b        = tb;
        cin      = tc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_carry got=%b exp=0", cout); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
`ifdef CSEL_ADDER_OVERFLOW_EN
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL wrap_result got=%h exp=%h", result, 32'h0); end
        n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL wrap_carry got=%b exp=1", cout); end
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL wrap_valid got=%b exp=1", valid_out); end
    endtask

    task automatic test_block_select();
        step(1'b0, 1'b1, 32'h0000_000F, 32'h0000_0001, 1'b0);
        n_cmp++; if (result !== 32'h0000_0010) begin n_err++; $display("FAIL blksel_result got=%h exp=%h", result, 32'h10); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL blksel_carry got=%b exp=0", cout); end
        step(1'b0, 1'b1, 32'h0FFF_FFF0, 32'h0000_0010, 1'b0);
        n_cmp++; if (result !== 32'h1000_0000) begin n_err++; $display("FAIL blksel2_result got=%h exp=%h", result, 32'h1000_0000); end
    endtask

    task automatic test_full_chain();
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL chain_result got=%h exp=%h", result, 32'h0); end
        n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL chain_carry got=%b exp=1", cout); end
        step(1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL hold_result got=%h exp=%h", result, 32'h0); end
        n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL hold_carry got=%b exp=1", cout); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL hold_valid got=%b exp=0", valid_out); end
        step(1'b0, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL alt_result got=%h exp=%h", result, 32'h0); end
        n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL alt_carry got=%b exp=1", cout); end
    endtask

    task automatic test_sub();
        step(1'b0, 1'b1, 32'h0000_0005, 32'hFFFF_FFFD, 1'b0);
        n_cmp++; if (result !== 32'h0000_0002) begin n_err++; $display("FAIL sub5m3_result got=%h exp=%h", result, 32'h2); end
        n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL sub5m3_carry got=%b exp=1", cout); end
        // 3 - 10 via ~B and carry_i=1: borrow, so carry_o=0
        step(1'b0, 1'b1, 32'h0000_0003, ~32'h0000_000A, 1'b1);
        n_cmp++; if (result !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL sub3m10_result got=%h exp=%h", result, 32'hFFFF_FFF9); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL sub3m10_carry got=%b exp=0", cout); end
        step(1'b0, 1'b1, 32'h8765_4321, 32'h1234_5678, 1'b0);
        n_cmp++; if (result !== 32'h9999_9999) begin n_err++; $display("FAIL mix_result got=%h exp=%h", result, 32'h9999_9999); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL mix_carry got=%b exp=0", cout); end
    endtask

`ifdef CSEL_ADDER_OVERFLOW_EN
    task automatic test_overflow();
        step(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        n_cmp++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_result got=%h exp=%h", result, 32'h8000_0000); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
        step(1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_hold got=%b exp=1", ovf); end
        step(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_neg got=%b exp=1", ovf); end
        step(1'b0, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] exp_sum;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            if (i % 2 == 0) begin
                rb = $urandom;
                rc = 1'($urandom_range(0, 1));
            end else begin
                rb = ~32'($urandom);
                rc = 1'b1;
            end
            exp_sum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            step(1'b0, 1'b1, ra, rb, rc);
            n_cmp++;
            if ({cout, result} !== exp_sum || valid_out !== 1'b1) begin
                n_err++;
                $display("FAIL rand[%0d] a=%h b=%h c=%b got=%b_%h v=%b exp=%b_%h v=1",
                         i, ra, rb, rc, cout, result, valid_out, exp_sum[32], exp_sum[31:0]);
            end
`ifdef CSEL_ADDER_OVERFLOW_EN
            n_cmp++;
            if (ovf !== ((ra[31] == rb[31]) && (exp_sum[31] != ra[31]))) begin
                n_err++;
                $display("FAIL rand_ovf[%0d] got=%b", i, ovf);
            end
`endif
        end
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        test_reset();
        test_wrap();
        test_block_select();
        test_full_chain();
        test_sub();
`ifdef CSEL_ADDER_OVERFLOW_EN
        test_overflow();
`endif
        test_back_to_back();
        // reset in the middle of traffic clears the stage
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        n_cmp++; if ({cout, result, valid_out} !== 34'h0) begin n_err++; $display("FAIL mid_reset got=%b_%h_%b exp=0_00000000_0", cout, result, valid_out); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
